// File: rtl/vo_pix_if.sv
// Pixel pull handshake between the video timing controller and an FWFT pixel source.
// The controller (master) pops with pix_req; the source (slave) presents pix_valid/pix_rgb.
interface vo_pix_if;
  logic        pix_req;
  logic        pix_valid;
  logic [23:0] pix_rgb;

  modport master (output pix_req, input pix_valid, input pix_rgb);
  modport slave  (input pix_req, output pix_valid, output pix_rgb);
endinterface

// File: rtl/vo_timing_ctrl.sv
// Raster timing generator for the video-output PHY: counts h/v position, pulls pixels
// from an FWFT source and registers sync/de/rgb. Starts and stops only on frame boundaries.
module vo_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic        i_vtc_clk,
  input  logic        i_vtc_rst_n,
  input  logic        i_en,
  input  logic        i_clr_status,
  vo_pix_if.master    pix,
  output logic        o_phy_hsync,
  output logic        o_phy_vsync,
  output logic        o_phy_de,
  output logic [7:0]  o_phy_red,
  output logic [7:0]  o_phy_green,
  output logic [7:0]  o_phy_blue,
  output logic        o_sof,
  output logic        o_busy,
  output logic        o_underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          sof_q, sof_d;
  logic          underflow_q, underflow_d;

  logic running, h_last, v_last, active, req, frame_end;

  always_comb begin
    running   = (state_q != IDLE);
    h_last    = (h_q == H_LAST);
    v_last    = (v_q == V_LAST);
    frame_end = h_last && v_last;
    active    = (h_q < H_ACT) && (v_q < V_ACT);
    req       = active && running;

    state_d = state_q;
    case (state_q)
      IDLE:    if (i_en) state_d = RUN;
      RUN:     if (!i_en) state_d = DRAIN;
      DRAIN:   if (i_en) state_d = RUN;
               else if (frame_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Counters sit at 0 in IDLE so the first RUN cycle is always h=0, v=0.
    h_d = '0;
    v_d = '0;
    if (running) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
        v_d = v_q;
      end
    end

    hsync_d = (running && h_q >= HS_START && h_q < HS_END) ? HS_POL : ~HS_POL;
    vsync_d = (running && v_q >= VS_START && v_q < VS_END) ? VS_POL : ~VS_POL;
    de_d    = req;
    rgb_d   = (req && pix.pix_valid) ? pix.pix_rgb : 24'h0;
    sof_d   = running && (h_q == '0) && (v_q == '0);

    // A fresh underflow beats a simultaneous clear so no event is lost.
    underflow_d = underflow_q;
    if (req && !pix.pix_valid) underflow_d = 1'b1;
    else if (i_clr_status)     underflow_d = 1'b0;
  end

  always_ff @(posedge i_vtc_clk or negedge i_vtc_rst_n) begin
    if (!i_vtc_rst_n) begin
      state_q     <= IDLE;
      h_q         <= '0;
      v_q         <= '0;
      hsync_q     <= ~HS_POL;
      vsync_q     <= ~VS_POL;
      de_q        <= 1'b0;
      rgb_q       <= 24'h0;
      sof_q       <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      hsync_q     <= hsync_d;
      vsync_q     <= vsync_d;
      de_q        <= de_d;
      rgb_q       <= rgb_d;
      sof_q       <= sof_d;
      underflow_q <= underflow_d;
    end
  end

  assign pix.pix_req  = req;
  assign o_phy_hsync  = hsync_q;
  assign o_phy_vsync  = vsync_q;
  assign o_phy_de     = de_q;
  assign o_phy_red    = rgb_q[23:16];
  assign o_phy_green  = rgb_q[15:8];
  assign o_phy_blue   = rgb_q[7:0];
  assign o_sof        = sof_q;
  assign o_busy       = running;
  assign o_underflow  = underflow_q;

endmodule

// File: tb/tb_vo_timing_ctrl.sv
// Bench for vo_timing_ctrl on a small raster (H 4/1/2/1, V 3/1/1/1): frame-position
// reference model, table of run segments, hand-written corner sequences, random run.
module tb_vo_timing_ctrl;
  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  logic hs, vs, de, sof, busy, uf;
  logic [7:0] red, green, blue;

  vo_pix_if pix ();

  vo_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .i_vtc_clk(clk), .i_vtc_rst_n(rst_n), .i_en(en), .i_clr_status(clr),
    .pix(pix),
    .o_phy_hsync(hs), .o_phy_vsync(vs), .o_phy_de(de),
    .o_phy_red(red), .o_phy_green(green), .o_phy_blue(blue),
    .o_sof(sof), .o_busy(busy), .o_underflow(uf)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int bad = 0;
  int cyc = 0;
  int s_req, s_sof, s_de;
  int sofq[$];
  logic [23:0] pix_ctr = 24'h000100;

  // Reference model: running flag plus position within the 48-cycle frame.
  bit m_run, m_enp;
  int m_pos;
  bit e_hs, e_vs, e_de, e_sof, e_uf;
  logic [23:0] e_rgb;

  typedef struct {
    int n;
    bit en;
    bit valid;
    int req;
    int sof;
    int de;
  } seg_t;
  seg_t segs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_enp = 0; m_pos = 0;
    e_hs = 1; e_vs = 1; e_de = 0; e_rgb = 24'h0; e_sof = 0; e_uf = 0;
  endtask

  function automatic logic [31:0] dut_vec();
    return {pix.pix_req, hs, vs, de, red, green, blue, sof, busy, uf};
  endfunction

  task automatic run_cycle(input bit e, input bit v, input logic [23:0] rgb, input bit c);
    int h, ln;
    bit act, e_req;
    en = e; pix.pix_valid = v; pix.pix_rgb = rgb; clr = c;
    h = m_pos % HT;
    ln = m_pos / HT;
    act = m_run && h < HA && ln < VA;
    e_hs = !(m_run && h >= HA + HF && h < HA + HF + HS);
    e_vs = !(m_run && ln >= VA + VF && ln < VA + VF + VS);
    e_de = act;
    e_rgb = (act && v) ? rgb : 24'h0;
    e_sof = m_run && m_pos == 0;
    if (act && !v) e_uf = 1;
    else if (c) e_uf = 0;
    // A frame ends only if enable was low on both of its last two cycles.
    if (!m_run) begin
      if (e) begin m_run = 1; m_enp = 1; end
      m_pos = 0;
    end else if (m_pos == FRAME - 1 && !e && !m_enp) begin
      m_run = 0; m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % FRAME;
      m_enp = e;
    end
    @(posedge clk); #1;
    cyc++;
    e_req = m_run && (m_pos % HT) < HA && (m_pos / HT) < VA;
    chk($sformatf("cyc%0d {req,hs,vs,de,rgb,sof,busy,uf}", cyc), 64'(dut_vec()),
        64'({e_req, e_hs, e_vs, e_de, e_rgb, e_sof, m_run, e_uf}));
    s_req += int'(pix.pix_req);
    s_sof += int'(sof);
    s_de  += int'(de);
    if (sof) sofq.push_back(cyc);
  endtask

  task automatic run_until(input int pos);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (m_run && m_pos == pos) begin ok = 1; break; end
      run_cycle(1, 1, pix_ctr, 0);
      pix_ctr++;
    end
    if (!ok) begin
      bad++;
      $display("FAIL run_until pos %0d: budget expired, got pos %0d", pos, m_pos);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk(name, 64'(dut_vec()), 64'({1'b0, 1'b1, 1'b1, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, rel;
    bit e;
    segs[0] = '{n: 5,  en: 0, valid: 1, req: 0,  sof: 0, de: 0};
    segs[1] = '{n: 1,  en: 1, valid: 1, req: 1,  sof: 0, de: 0};
    segs[2] = '{n: 48, en: 1, valid: 1, req: 12, sof: 1, de: 12};
    segs[3] = '{n: 48, en: 1, valid: 0, req: 12, sof: 1, de: 12};
    segs[4] = '{n: 48, en: 0, valid: 1, req: 11, sof: 1, de: 12};
    segs[5] = '{n: 10, en: 0, valid: 1, req: 0,  sof: 0, de: 0};

    model_reset();
    pix.pix_valid = 1'b1;
    pix.pix_rgb = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset values");
    rst_n = 1'b1;

    // Steady-state segments: per-cycle model check plus per-segment totals.
    for (int i = 0; i < 6; i++) begin
      s_req = 0; s_sof = 0; s_de = 0;
      for (int k = 0; k < segs[i].n; k++) begin
        run_cycle(segs[i].en, segs[i].valid, pix_ctr, 0);
        pix_ctr++;
      end
      chk($sformatf("seg%0d req count", i), 64'(s_req), 64'(segs[i].req));
      chk($sformatf("seg%0d sof count", i), 64'(s_sof), 64'(segs[i].sof));
      chk($sformatf("seg%0d de count", i), 64'(s_de), 64'(segs[i].de));
    end

    // Underflow from the all-invalid frame is still sticky; clear it.
    chk("uf sticky after idle", 64'(uf), 64'd1);
    run_cycle(0, 1, 24'h0, 1);
    chk("uf cleared", 64'(uf), 64'd0);

    // Single missing pixel at h=1, v=1.
    run_until(9);
    run_cycle(1, 0, 24'hABCDEF, 0);
    chk("missing pixel black", 64'({red, green, blue}), 64'd0);
    for (int k = 0; k < 5; k++) begin run_cycle(1, 1, pix_ctr, 0); pix_ctr++; end
    chk("uf set and sticky", 64'(uf), 64'd1);
    run_cycle(1, 1, pix_ctr, 1);
    pix_ctr++;
    chk("uf clear pulse", 64'(uf), 64'd0);

    // Enable dropped at h=2, v=1: busy until the frame's last cycle, then idle.
    run_until(10);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      run_cycle(0, 1, pix_ctr, 0);
      pix_ctr++;
      if (!busy) break;
      n++;
    end
    chk("busy cycles after drop", 64'(n), 64'd37);
    s_sof = 0;
    for (int k = 0; k < 20; k++) run_cycle(0, 1, 24'h123456, 0);
    chk("no sof in idle", 64'(s_sof), 64'd0);
    chk("idle sync/de", 64'({hs, vs, de}), 64'b110);

    // Enable dropped then re-raised inside a frame: sof period stays 48.
    sofq.delete();
    for (int k = 0; k < 300 && sofq.size() < 3; k++) begin
      e = !(k >= 60 && k < 70);
      run_cycle(e, 1, pix_ctr, 0);
      pix_ctr++;
    end
    if (sofq.size() >= 3) begin
      chk("sof period 1", 64'(sofq[1] - sofq[0]), 64'd48);
      chk("sof period 2", 64'(sofq[2] - sofq[1]), 64'd48);
    end else begin
      bad++;
      $display("FAIL sof period: only %0d sof pulses, want 3", sofq.size());
    end

    // Asynchronous reset in the middle of an active line.
    run_until(9);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async reset immediate");
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk_reset_vals("reset held");
    en = 1'b1;
    rst_n = 1'b1;
    rel = cyc;
    sofq.delete();
    for (int k = 0; k < 60; k++) begin run_cycle(1, 1, pix_ctr, 0); pix_ctr++; end
    if (sofq.size() > 0) chk("sof after reset release", 64'(sofq[0] - rel), 64'd2);
    else begin
      bad++;
      $display("FAIL sof after reset release: no sof pulse after release, want cycle 2");
    end

    // Random enable bursts, source gaps and clear pulses against the model.
    e = 1;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 99) < 3) e = !e;
      run_cycle(e, ($urandom_range(0, 15) != 0), 24'($urandom), ($urandom_range(0, 31) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
